uart_fifo_gen: RTL and testbench
================================

# uart_fifo_gen

Parametrised synchronous FIFO for the UART datapath. It replaces the fixed 8-bit/16-deep buffer between the UART receiver/transmitter and the host interface, and adds:
- configurable width and depth
- occupancy count
- almost-full/almost-empty thresholds
- sticky overflow/underflow error flags
- an optional first-word-fall-through read mode

One instance sits on each direction: rx path (receiver → host) and tx path (host → transmitter).

## Interface
Parameters:
- DATA_W, 8, word width in bits
- DEPTH, 16, number of entries; power of two, ≥ 2
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH
- AE_THRESH, 2, almost_empty asserts when count ≤ AE_THRESH; legal range AE_THRESH < AF_THRESH ≤ DEPTH

Ports:
- clk  in  1  clock; all logic on rising edge
- srst  in  1  reset; synchronous, active-high
- din  in  DATA_W  write data
- wr_en  in  1  write request
- rd_en  in  1  read/pop request
- err_clr  in  1  clears overflow and underflow
- dout  out  DATA_W  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky; a write was attempted while full
- underflow  out  1  sticky; a read was attempted while empty

## Operation
- Pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit, and the low bits address storage. Both pointers wrap naturally from DEPTH-1 to 0.
- Accept rules use flags as registered at the start of the cycle:
  - write accepted iff wr_en && !full
  - read accepted iff rd_en && !empty
- Simultaneous wr_en and rd_en:
  - when neither full nor empty: both accepted, count unchanged
  - when full: read accepted, write rejected, overflow set
  - when empty: write accepted, read rejected, underflow set
- count update: +1 (write only), −1 (read only), 0 (both accepted or neither). It never exceeds DEPTH and never wraps below 0.
- full, empty, almost_full and almost_empty are decoded combinationally from the registered count.
- overflow/underflow set on a rejected request and hold until err_clr. If a set and err_clr occur in the same cycle, the set wins.
- srst forces:
  - pointers = 0, count = 0, dout = 0
  - overflow = 0, underflow = 0
  - storage contents are not cleared
- srst mid-operation discards all stored data. It takes priority over wr_en, rd_en and err_clr in the same cycle.
- Reset output values: dout 0, full 0, empty 1, almost_full 0, almost_empty 1, count 0, overflow 0, underflow 0.

## Timing
- Write accepted at edge N → count and flags reflect it after edge N (visible in cycle N+1).
- Standard mode read: rd_en accepted at edge N → dout holds the popped word from cycle N+1. dout keeps its last value when no read is accepted.
- FWFT mode read: dout shows the head entry combinationally whenever empty = 0. After rd_en at edge N, dout shows the next entry in cycle N+1. dout is undefined while empty = 1.
- Write into an empty FIFO at edge N → empty deasserts in cycle N+1, in both modes. In FWFT mode, dout is already valid in that cycle.
- Throughput is one write and one read per cycle, sustained.

## Configuration
- Macro UART_FIFO_FWFT_EN.
- Defined: first-word-fall-through read (combinational read of the head entry, as above).
- Undefined: standard registered read, with one-cycle rd_en→dout latency and dout reset to 0.
- Flags, count, error behaviour and accept rules are identical in both builds.

## Structure
- Package uart_fifo_pkg holds:
  - default constants UART_FIFO_DATA_W = 8 and UART_FIFO_DEPTH = 16
  - a function computing pointer width from depth
  - the parameter legality check, which is elaborated by the top
- Sub-module uart_fifo_ram provides the storage: a simple dual-port register array with one write port and one read port. The read port is asynchronous under UART_FIFO_FWFT_EN and registered otherwise.
- uart_fifo_gen contains the pointers, count, flag decode, error flags and accept logic.

## Test plan
All scenarios use DEPTH=16, DATA_W=8, AF_THRESH=14, AE_THRESH=2.
- Reset: assert srst for 2 cycles → count=0, empty=1, almost_empty=1, full=0, almost_full=0, dout=0, overflow=underflow=0.
- Fill and drain: write 0x00..0x0F, then read 16 times.
  - full=1 once count=16; almost_full=1 from count=14
  - reads return 0x00..0x0F in order; empty=1 after the last read
- Overflow: FIFO full, wr_en with din=0xAA → write dropped, overflow=1, count stays 16. Then err_clr → overflow=0.
- Simultaneous access:
  - wr_en+rd_en at count=5 → count stays 5, data order preserved
  - wr_en+rd_en at count=0 → count=1, underflow=1
  - wr_en+rd_en at count=16 → count=15, overflow=1
- Wrap-around: 40 cycles of concurrent write/read with incrementing data, count held at 3 → pointers wrap twice, output sequence is gap-free.
- Reset mid-operation: srst at count=9 while wr_en=1 → count=0 next cycle, empty=1. A subsequent single write of 0x5C reads back 0x5C. Checks cover both UART_FIFO_FWFT_EN builds.

Source files
------------

// File: rtl/uart_fifo_pkg.sv
// Shared constants and elaboration helpers for the UART datapath FIFO.
package uart_fifo_pkg;

   localparam int unsigned UART_FIFO_DATA_W = 8;
   localparam int unsigned UART_FIFO_DEPTH  = 16;

   // Pointer width: address bits plus one wrap bit.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

   // Depth must be a power of two >= 2 and AE_THRESH < AF_THRESH <= DEPTH.
   function automatic bit params_legal(input int unsigned depth,
                                       input int unsigned af_thresh,
                                       input int unsigned ae_thresh);
      return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
             (ae_thresh < af_thresh) && (af_thresh <= depth);
   endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port storage for uart_fifo_gen.
// UART_FIFO_FWFT_EN: read port is asynchronous; otherwise it is registered and resets to 0.
module uart_fifo_ram
   import uart_fifo_pkg::*;
#(
   parameter int unsigned DATA_W = UART_FIFO_DATA_W,
   parameter int unsigned DEPTH  = UART_FIFO_DEPTH,
   parameter int unsigned AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              srst,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Storage write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

`ifdef UART_FIFO_FWFT_EN
   logic unused_ok;
   assign unused_ok = ^{srst, re_i};

   // Head entry falls through combinationally.
   assign rdata_o = mem_q[raddr_i];
`else
   logic [DATA_W-1:0] rdata_q;

   // Registered read: popped word appears the cycle after the accepted read.
   always_ff @(posedge clk) begin
      if (srst)      rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/uart_fifo_gen.sv
// Parametrised synchronous FIFO with occupancy, thresholds and sticky error flags.
// Optional first-word-fall-through read mode via macro UART_FIFO_FWFT_EN.
module uart_fifo_gen
   import uart_fifo_pkg::*;
#(
   parameter int unsigned DATA_W    = UART_FIFO_DATA_W,
   parameter int unsigned DEPTH     = UART_FIFO_DEPTH,
   parameter int unsigned AF_THRESH = DEPTH - 2,
   parameter int unsigned AE_THRESH = 2,
   localparam int unsigned PW       = ptr_width(DEPTH),
   localparam int unsigned AW       = PW - 1
) (
   input  logic              clk,
   input  logic              srst,
   input  logic [DATA_W-1:0] din,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic              err_clr,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [PW-1:0]     count,
   output logic              overflow,
   output logic              underflow
);

   // Reject illegal parameter sets at elaboration.
   if (!params_legal(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
      $error("uart_fifo_gen: illegal DEPTH/AF_THRESH/AE_THRESH");
   end

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;
   logic          wr_acc, rd_acc;

   // Flags decode from the registered count.
   assign full         = (count_q == PW'(DEPTH));
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= PW'(AF_THRESH));
   assign almost_empty = (count_q <= PW'(AE_THRESH));
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   assign wr_acc = wr_en && !full;
   assign rd_acc = rd_en && !empty;

   // Next-state: pointer advance, occupancy and sticky errors (set beats clear).
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q + PW'(wr_acc) - PW'(rd_acc);
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
      if (err_clr) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (wr_en && full)  overflow_d  = 1'b1;
      if (rd_en && empty) underflow_d = 1'b1;
   end

   // State registers; srst discards all stored data.
   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   uart_fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk     (clk),
      .srst    (srst),
      .we_i    (wr_acc),
      .waddr_i (wr_ptr_q[AW-1:0]),
      .wdata_i (din),
      .re_i    (rd_acc),
      .raddr_i (rd_ptr_q[AW-1:0]),
      .rdata_o (dout)
   );

endmodule

// File: tb/tb_uart_fifo_gen.sv
// Self-checking bench for uart_fifo_gen against a queue-based reference model.
module tb_uart_fifo_gen;

   localparam int DEPTH = 16;
   localparam int AF    = 14;
   localparam int AE    = 2;

   logic       clk = 1'b0;
   logic       srst = 1'b0, wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
   logic [7:0] din = '0;
   logic [7:0] dout;
   logic       full, empty, almost_full, almost_empty;
   logic [4:0] count;
   logic       overflow, underflow;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] m_q[$];
   logic       m_ovf = 1'b0, m_unf = 1'b0;
   logic [7:0] m_dout = '0;

   uart_fifo_gen #(.DATA_W(8), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
      .clk(clk), .srst(srst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
      .err_clr(err_clr), .dout(dout), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs, advance the model across the edge, sample 1ns later.
   task automatic step(input logic w, input logic r, input logic [7:0] d,
                       input logic clr, input logic rst);
      logic was_full, was_empty;
      wr_en = w; rd_en = r; din = d; err_clr = clr; srst = rst;
      @(posedge clk);
      was_full  = (m_q.size() == DEPTH);
      was_empty = (m_q.size() == 0);
      if (rst) begin
         m_q.delete();
         m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;
      end else begin
         if (r && !was_empty) m_dout = m_q.pop_front();
         if (w && !was_full) m_q.push_back(d);
         if (w && was_full) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
         if (r && was_empty) m_unf = 1'b1; else if (clr) m_unf = 1'b0;
      end
      #1;
      wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; srst = 1'b0;
   endtask

   task automatic test_reset();
      step(0, 0, 8'h00, 0, 1);
      step(0, 0, 8'h00, 0, 1);
      n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL reset_count got %0d exp 0", count); end
      n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty got %b exp 1", empty); end
      n_checks++; if (almost_empty !== 1'b1) begin n_errors++; $display("FAIL reset_ae got %b exp 1", almost_empty); end
      n_checks++; if (full !== 1'b0) begin n_errors++; $display("FAIL reset_full got %b exp 0", full); end
      n_checks++; if (almost_full !== 1'b0) begin n_errors++; $display("FAIL reset_af got %b exp 0", almost_full); end
      n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
         n_errors++; $display("FAIL reset_err got ovf=%b unf=%b exp 0 0", overflow, underflow); end
`ifndef UART_FIFO_FWFT_EN
      n_checks++; if (dout !== 8'h00) begin n_errors++; $display("FAIL reset_dout got %h exp 00", dout); end
`endif
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < DEPTH; i++) begin
         step(1, 0, 8'(i), 0, 0);
         n_checks++; if (count !== 5'(i + 1)) begin n_errors++; $display("FAIL fill_count got %0d exp %0d", count, i + 1); end
         n_checks++; if (full !== (i + 1 == DEPTH)) begin n_errors++; $display("FAIL fill_full at %0d got %b", i + 1, full); end
         n_checks++; if (almost_full !== (i + 1 >= AF)) begin n_errors++; $display("FAIL fill_af at %0d got %b", i + 1, almost_full); end
         n_checks++; if (almost_empty !== (i + 1 <= AE)) begin n_errors++; $display("FAIL fill_ae at %0d got %b", i + 1, almost_empty); end
      end
      for (int i = 0; i < DEPTH; i++) begin
`ifdef UART_FIFO_FWFT_EN
         n_checks++; if (dout !== 8'(i)) begin n_errors++; $display("FAIL drain_dout got %h exp %h", dout, 8'(i)); end
         step(0, 1, 8'h00, 0, 0);
`else
         step(0, 1, 8'h00, 0, 0);
         n_checks++; if (dout !== 8'(i)) begin n_errors++; $display("FAIL drain_dout got %h exp %h", dout, 8'(i)); end
`endif
      end
      n_checks++; if (empty !== 1'b1 || count !== 5'd0) begin
         n_errors++; $display("FAIL drain_empty got empty=%b count=%0d exp 1 0", empty, count); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < DEPTH; i++) step(1, 0, 8'($urandom_range(0, 255)), 0, 0);
      step(1, 0, 8'hAA, 0, 0);
      n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
      n_checks++; if (count !== 5'd16) begin n_errors++; $display("FAIL ovf_count got %0d exp 16", count); end
      step(0, 0, 8'h00, 1, 0);
      n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_clr got %b exp 0", overflow); end
      for (int i = 0; i < DEPTH; i++) begin
`ifdef UART_FIFO_FWFT_EN
         n_checks++; if (dout !== m_q[0]) begin n_errors++; $display("FAIL ovf_drain got %h exp %h", dout, m_q[0]); end
         step(0, 1, 8'h00, 0, 0);
`else
         step(0, 1, 8'h00, 0, 0);
         n_checks++; if (dout !== m_dout) begin n_errors++; $display("FAIL ovf_drain got %h exp %h", dout, m_dout); end
`endif
      end
   endtask

   task automatic test_simultaneous();
      step(0, 0, 8'h00, 0, 1);
      for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h40 + i), 0, 0);
      step(1, 1, 8'h77, 0, 0);
      n_checks++; if (count !== 5'd5) begin n_errors++; $display("FAIL sim5_count got %0d exp 5", count); end
`ifndef UART_FIFO_FWFT_EN
      n_checks++; if (dout !== 8'h40) begin n_errors++; $display("FAIL sim5_dout got %h exp 40", dout); end
`endif
      for (int i = 0; i < 5; i++) begin
`ifdef UART_FIFO_FWFT_EN
         n_checks++; if (dout !== m_q[0]) begin n_errors++; $display("FAIL sim5_order got %h exp %h", dout, m_q[0]); end
         step(0, 1, 8'h00, 0, 0);
`else
         step(0, 1, 8'h00, 0, 0);
         n_checks++; if (dout !== m_dout) begin n_errors++; $display("FAIL sim5_order got %h exp %h", dout, m_dout); end
`endif
      end
      step(1, 1, 8'h12, 0, 0);
      n_checks++; if (count !== 5'd1) begin n_errors++; $display("FAIL sim0_count got %0d exp 1", count); end
      n_checks++; if (underflow !== 1'b1) begin n_errors++; $display("FAIL sim0_unf got %b exp 1", underflow); end
      step(0, 0, 8'h00, 1, 0);
      for (int i = 0; i < DEPTH - 1; i++) step(1, 0, 8'(i), 0, 0);
      step(1, 1, 8'h99, 0, 0);
      n_checks++; if (count !== 5'd15) begin n_errors++; $display("FAIL sim16_count got %0d exp 15", count); end
      n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL sim16_ovf got %b exp 1", overflow); end
   endtask

   task automatic test_wrap();
      step(0, 0, 8'h00, 0, 1);
      for (int i = 0; i < 3; i++) step(1, 0, 8'(i), 0, 0);
      for (int k = 0; k < 40; k++) begin
         step(1, 1, 8'(k + 3), 0, 0);
         n_checks++; if (count !== 5'd3) begin n_errors++; $display("FAIL wrap_count got %0d exp 3", count); end
`ifdef UART_FIFO_FWFT_EN
         n_checks++; if (dout !== 8'(k + 1)) begin n_errors++; $display("FAIL wrap_dout got %h exp %h", dout, 8'(k + 1)); end
`else
         n_checks++; if (dout !== 8'(k)) begin n_errors++; $display("FAIL wrap_dout got %h exp %h", dout, 8'(k)); end
`endif
      end
   endtask

   task automatic test_reset_mid();
      step(0, 0, 8'h00, 0, 1);
      for (int i = 0; i < 9; i++) step(1, 0, 8'(8'hB0 + i), 0, 0);
      step(1, 0, 8'h33, 0, 1);
      n_checks++; if (count !== 5'd0 || empty !== 1'b1) begin
         n_errors++; $display("FAIL rstmid got count=%0d empty=%b exp 0 1", count, empty); end
      step(1, 0, 8'h5C, 0, 0);
`ifdef UART_FIFO_FWFT_EN
      n_checks++; if (empty !== 1'b0 || dout !== 8'h5C) begin
         n_errors++; $display("FAIL rstmid_read got empty=%b dout=%h exp 0 5c", empty, dout); end
`else
      step(0, 1, 8'h00, 0, 0);
      n_checks++; if (dout !== 8'h5C) begin n_errors++; $display("FAIL rstmid_read got %h exp 5c", dout); end
`endif
   endtask

   task automatic test_random();
      int sz;
      logic w, r, clr, rst;
      step(0, 0, 8'h00, 0, 1);
      for (int c = 0; c < 800; c++) begin
         w   = ($urandom_range(0, 99) < (((c / 100) % 2) ? 80 : 30));
         r   = ($urandom_range(0, 99) < (((c / 100) % 2) ? 30 : 80));
         clr = ($urandom_range(0, 15) == 0);
         rst = ($urandom_range(0, 299) == 0);
         step(w, r, 8'($urandom_range(0, 255)), clr, rst);
         sz = m_q.size();
         n_checks++; if (count !== 5'(sz)) begin n_errors++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", c, count, sz); end
         n_checks++; if ({full, empty, almost_full, almost_empty} !== {sz == DEPTH, sz == 0, sz >= AF, sz <= AE}) begin
            n_errors++; $display("FAIL rnd_flags cyc %0d got %b exp %b", c, {full, empty, almost_full, almost_empty},
                                 {sz == DEPTH, sz == 0, sz >= AF, sz <= AE}); end
         n_checks++; if ({overflow, underflow} !== {m_ovf, m_unf}) begin
            n_errors++; $display("FAIL rnd_err cyc %0d got %b%b exp %b%b", c, overflow, underflow, m_ovf, m_unf); end
`ifdef UART_FIFO_FWFT_EN
         if (sz != 0) begin
            n_checks++; if (dout !== m_q[0]) begin n_errors++; $display("FAIL rnd_dout cyc %0d got %h exp %h", c, dout, m_q[0]); end
         end
`else
         n_checks++; if (dout !== m_dout) begin n_errors++; $display("FAIL rnd_dout cyc %0d got %h exp %h", c, dout, m_dout); end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_overflow();
      test_simultaneous();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
